mem_rr_arbiter: RTL

- Round-robin arbiter that shares the single-client port of the memory interface among CLIENT_CNT requesters (fetch, load/store, debug).
- Sits between the requesters and the memory interface's client-side signals.
- Grants exactly one client per transaction and holds the grant until that transaction's ready/request handshake closes.
- Advances priority after each grant, so no requester starves.

---
 rtl/mem_rr_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one memory-interface client port among CLIENT_CNT requesters.
// A grant is held until the winner drops its request; RELEASE waits for mem_ready to fall before the next arbitration.
module mem_rr_arbiter #(
    parameter int M_WIDTH = 8,
    parameter int CLIENT_CNT = 2,
    localparam int IDX_W = $clog2(CLIENT_CNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CLIENT_CNT-1:0]         client_requests,
    input  logic [CLIENT_CNT*M_WIDTH-1:0] client_addrs_packed,
    input  logic [CLIENT_CNT-1:0]         client_wes,
    input  logic [2*CLIENT_CNT-1:0]       client_data_widths_packed,
    input  logic [CLIENT_CNT*M_WIDTH-1:0] client_data_outs_packed,
    output logic [CLIENT_CNT*M_WIDTH-1:0] client_data_ins_packed,
    output logic [CLIENT_CNT-1:0]         client_readies,
    output logic                          mem_request,
    output logic [M_WIDTH-1:0]            mem_addr,
    output logic                          mem_we_out,
    output logic [1:0]                    mem_data_width,
    output logic [M_WIDTH-1:0]            mem_data_out,
    input  logic [M_WIDTH-1:0]            mem_data_in,
    input  logic                          mem_ready,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_idx
);
    typedef enum logic [1:0] {IDLE = 2'b00, GRANT = 2'b01, RELEASE = 2'b10} state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr, r_grant_idx, w_pick, w_cand, w_rr_next;
    logic             w_found, w_gnt, w_req_g;

    // Scan from the farthest offset down so the closest requester to rr_ptr is kept.
    always_comb begin
        w_found = 1'b0;
        w_pick = '0;
        w_cand = '0;
        for (int k = CLIENT_CNT - 1; k >= 0; k--) begin
            w_cand = IDX_W'((int'(r_rr_ptr) + k) % CLIENT_CNT);
            if (client_requests[w_cand]) begin
                w_found = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    assign w_rr_next = (r_grant_idx == IDX_W'(CLIENT_CNT - 1)) ? '0 : r_grant_idx + 1'b1;
    assign w_gnt = (r_state == GRANT);
    assign w_req_g = client_requests[r_grant_idx];

    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = w_found ? GRANT : IDLE;
            GRANT:   w_state_nxt = w_req_g ? GRANT : RELEASE;
            RELEASE: w_state_nxt = mem_ready ? RELEASE : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_rr_ptr <= '0;
            r_grant_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_found)
                r_grant_idx <= w_pick;
            if (w_gnt && !w_req_g)
                r_rr_ptr <= w_rr_next;
        end
    end

    assign grant_valid = w_gnt;
    assign grant_idx = r_grant_idx;
    assign mem_request = w_gnt & w_req_g;
    assign mem_addr = w_gnt ? client_addrs_packed[r_grant_idx*M_WIDTH +: M_WIDTH] : '0;
    assign mem_we_out = w_gnt & client_wes[r_grant_idx];
    assign mem_data_width = w_gnt ? client_data_widths_packed[r_grant_idx*2 +: 2] : 2'b00;
    assign mem_data_out = w_gnt ? client_data_outs_packed[r_grant_idx*M_WIDTH +: M_WIDTH] : '0;

    always_comb begin
        client_readies = '0;
        client_data_ins_packed = '0;
        if (w_gnt) begin
            client_readies[r_grant_idx] = mem_ready;
            client_data_ins_packed[r_grant_idx*M_WIDTH +: M_WIDTH] = mem_data_in;
        end
    end
endmodule
